// File: rtl/rstseq_pkg.sv
// Shared state encoding and default parameters for the reset sequencer.
package rstseq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        MEM_UP    = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_LOCK_CYCLES     = 1024;
    localparam int DEF_CPU_DELAY       = 16;
    localparam int DEF_DEBOUNCE_CYCLES = 65536;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit.
module sync_bit
    import rstseq_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset release (memory first, CPU later) gated on a stable PLL lock.
// Optional debounced user button when RSTSEQ_BUTTON_EN is defined.
module reset_sequencer
    import rstseq_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int LOCK_CYCLES     = DEF_LOCK_CYCLES,
    parameter int CPU_DELAY       = DEF_CPU_DELAY,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic locked,
`ifdef RSTSEQ_BUTTON_EN
    input  logic btn,
`endif
    output logic rst_mem,
    output logic rst_cpu,
    output logic running
);

    localparam int CMAX = max_int(LOCK_CYCLES, CPU_DELAY);
    localparam int CW   = $clog2(CMAX + 1);

    if (SYNC_STAGES < 2 || LOCK_CYCLES < 1 || CPU_DELAY < 1
        || DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("reset_sequencer: parameter out of range");
    end

    logic          lock_s;
    logic          force_rst;
    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc;

    sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_sync_lock (
        .clk  (clk),
        .reset(reset),
        .d    (locked),
        .q    (lock_s)
    );

`ifdef RSTSEQ_BUTTON_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          btn_s;
    logic          btn_db;
    logic [DW-1:0] db_cnt;

    sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_sync_btn (
        .clk  (clk),
        .reset(reset),
        .d    (btn),
        .q    (btn_s)
    );

    // Level flips only after a full run of differing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else if (btn_s == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            btn_db <= btn_s;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DW'(1);
        end
    end

    assign force_rst = btn_db;
`else
    assign force_rst = 1'b0;
`endif

    assign cnt_inc = (cnt_q == CW'(CMAX)) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            WAIT_LOCK: begin
                if (!lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(LOCK_CYCLES - 1)) begin
                    state_d = MEM_UP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            MEM_UP: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(CPU_DELAY - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
        if (force_rst) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
        end
    end

    // Outputs come from next-state so lock loss reasserts on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            rst_mem <= 1'b1;
            rst_cpu <= 1'b1;
            running <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_mem <= (state_d == WAIT_LOCK);
            rst_cpu <= (state_d != RUN);
            running <= (state_d == RUN);
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with LOCK_CYCLES=8, CPU_DELAY=4.
// Button scenario runs only when RSTSEQ_BUTTON_EN is defined.
module tb_reset_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic locked;
    logic btn;
    logic rst_mem;
    logic rst_cpu;
    logic running;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .SYNC_STAGES    (2),
        .LOCK_CYCLES    (8),
        .CPU_DELAY      (4),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .locked (locked),
`ifdef RSTSEQ_BUTTON_EN
        .btn    (btn),
`endif
        .rst_mem(rst_mem),
        .rst_cpu(rst_cpu),
        .running(running)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic m,
                       input logic c, input logic r);
        checks++;
        assert ({rst_mem, rst_cpu, running} === {m, c, r}) else begin
            failures++;
            $error("FAIL %s observed=%b%b%b expected=%b%b%b",
                   tag, rst_mem, rst_cpu, running, m, c, r);
        end
    endtask

    // Edge 1 is the first posedge after reset falls with locked high.
    task automatic full_seq(input string tag);
        for (int e = 1; e <= 14; e++) begin
            step(1);
            chk($sformatf("%s_e%0d", tag, e), e < 10, e < 14, e >= 14);
        end
    endtask

    initial begin
        reset  = 1'b1;
        locked = 1'b1;
        btn    = 1'b0;

        // 1: locked high from the start
        step(3);
        chk("reset_state", 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        full_seq("t1");

        // 3: one-cycle lock drop while running
        locked = 1'b0;
        step(1);
        locked = 1'b1;
        chk("t3_e1", 1'b0, 1'b0, 1'b1);
        step(1);
        chk("t3_e2", 1'b0, 1'b0, 1'b1);
        step(1);
        chk("t3_e3", 1'b1, 1'b1, 1'b0);
        step(7);
        chk("t3_e10", 1'b1, 1'b1, 1'b0);
        step(1);
        chk("t3_e11", 1'b0, 1'b1, 1'b0);
        step(3);
        chk("t3_e14", 1'b0, 1'b1, 1'b0);
        step(1);
        chk("t3_e15", 1'b0, 1'b0, 1'b1);

        // 2: lock glitch before the count completes
        reset  = 1'b1;
        locked = 1'b0;
        #1;
        chk("t2_reset", 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step(1);
        locked = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            if (e == 6) locked = 1'b0;
            if (e == 7) locked = 1'b1;
            step(1);
            chk($sformatf("t2_e%0d", e), 1'b1, 1'b1, 1'b0);
        end
        step(1);
        chk("t2_e16", 1'b0, 1'b1, 1'b0);

        // 4: async reset in MEM_UP takes effect without an edge
        step(1);
        chk("t4_memup", 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        chk("t4_async", 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        full_seq("t4");

`ifdef RSTSEQ_BUTTON_EN
        // 5: short press is filtered, long press restarts the sequence
        btn = 1'b1;
        step(10);
        btn = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            step(1);
            chk($sformatf("t5s_e%0d", e), 1'b0, 1'b0, 1'b1);
        end
        btn = 1'b1;
        step(18);
        chk("t5_e18", 1'b0, 1'b0, 1'b1);
        step(1);
        chk("t5_e19", 1'b1, 1'b1, 1'b0);
        step(1);
        btn = 1'b0;
        step(25);
        chk("t5_e45", 1'b1, 1'b1, 1'b0);
        step(1);
        chk("t5_e46", 1'b0, 1'b1, 1'b0);
        step(3);
        chk("t5_e49", 1'b0, 1'b1, 1'b0);
        step(1);
        chk("t5_e50", 1'b0, 1'b0, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
